mod_i2s_tx: RTL and testbench
=============================

# mod_i2s_tx

Audio output end of the sample path. Paces sample sources by pulsing a per-frame trigger and captures the signed 18.14 sample returned with its ready pulse. Saturates the sample to 24-bit PCM and serializes it as mono (same value on both channels) in standard I2S format for the codec/DAC. Sample rate is i_clk / (128 × BCLK_DIV).

## Interface
- BCLK_DIV, 4: i_clk cycles per half BCLK period; minimum 2.
- i_clk  in  1  global clock.
- i_nrst  in  1  synchronous active-low reset.
- i_sample  in  32  signed 18.14 sample; valid only when i_ready=1.
- i_ready  in  1  single-cycle pulse qualifying i_sample.
- o_trigger  out  1  single-cycle request for the next sample; one pulse per frame.
- o_bclk  out  1  I2S bit clock.
- o_lrclk  out  1  I2S word select (0 = left, 1 = right).
- o_sdata  out  1  I2S serial data.
- o_underrun_cnt  out  16  saturating count of frames that reused the previous sample.
- o_overrun  out  1  sticky flag: more than one i_ready between two frame loads.

## Operation
- Divider: div_cnt counts 0..BCLK_DIV-1. At BCLK_DIV-1 it wraps to 0 and o_bclk toggles. A toggle 1→0 is a falling-edge event (FE).
- Slot counter 0..63 advances by 1 (mod 64) on each FE.
- o_lrclk = 1 for slots 31..62, 0 otherwise. It leads the data by one BCLK.
- o_sdata:
  - slots 0..23: left PCM bit 23−slot.
  - slots 32..55: right PCM bit 23−(slot−32).
  - all other slots: 0.
  - L and R PCM are the same frame register.
- All three I2S outputs are registers that update only on FE cycles, so data changes on BCLK falling edges and is sampled by the codec on rising edges.
- Holding register plus valid bit:
  - i_ready=1 writes i_sample into the holding register and sets valid.
  - If valid is already 1 when i_ready=1, the new value overwrites (last wins) and o_overrun sets.
- Frame load happens on the FE that enters slot 63:
  - If valid=1: frame register ← sat24(holding); valid clears.
  - If valid=0: frame register is unchanged. o_underrun_cnt increments, saturating at 0xFFFF. Exception: the first load after reset is never counted.
  - o_trigger pulses in this same cycle.
- i_ready in the frame-load cycle: the load uses the holding contents from before that cycle. The new sample is written to holding with valid=1 for the next frame. This case is not an overrun unless valid was already 1 and is not consumed by this load. Rule: the load clears valid first, then the write sets it.
- sat24(s) = clamp(s × 512, −2^23, 2^23−1), computed at ≥42-bit signed width.
  - 1.0 (0x4000) maps to 0x7FFFFF (clamped).
  - −1.0 maps to 0x800000.
- Reset values (i_nrst=0 at a clock edge):
  - o_bclk, o_lrclk, o_sdata, o_trigger, o_overrun = 0.
  - o_underrun_cnt = 0.
  - div_cnt = 0, slot = 62.
  - holding = 0, valid = 0, frame register = 0, first-load flag set.
  - Reset mid-frame aborts the frame immediately; no partial word completes.

## Timing
- Counting the first cycle with i_nrst=1 as cycle 1:
  - o_bclk rises at the end of cycle BCLK_DIV.
  - o_bclk falls at the end of cycle 2×BCLK_DIV. This is the first FE: it enters slot 63, o_lrclk goes 0, and o_trigger is high for that cycle.
- Frame period is 128×BCLK_DIV cycles; o_trigger repeats with this period.
- Source deadline: i_ready must arrive within 128×BCLK_DIV−1 cycles after o_trigger to be used at the next load.
- Sample-to-pin latency: the left MSB appears on o_sdata at the FE that enters slot 0, i.e. 2×BCLK_DIV cycles after the load.
- o_trigger is never high on consecutive cycles.

## Test plan
- Reset/startup (BCLK_DIV=4): all outputs 0 during reset. o_bclk rises after cycle 4 and falls after cycle 8, with o_trigger=1 in that cycle only. The next o_trigger comes 512 cycles later. o_underrun_cnt stays 0.
- Scaling: answer each trigger with i_sample = 0x00002000, then 0xFFFFE000, then 0x00000001. Decoded L and R words are 0x400000, 0xC00000, 0x000200. Bits 24..31 of each channel are 0. o_lrclk toggles one BCLK before each MSB.
- Saturation: 0x00004000 → 0x7FFFFF; 0x00050000 → 0x7FFFFF; 0xFFFFC000 → 0x800000; 0xFFFB0000 → 0x800000.
- Underrun: send 0x00001000, then skip two triggers. Three consecutive frames carry 0x200000 and o_underrun_cnt = 2. Forcing the counter to 0xFFFF and skipping once leaves it at 0xFFFF.
- Overrun and collision:
  - Two i_ready pulses (0x1000, then 0x2000) in one frame: the next frame carries 0x400000 and o_overrun=1.
  - i_ready=0x0800 exactly in the load cycle: the current frame keeps its old value and the following frame carries 0x100000.
- Mid-frame reset: assert i_nrst=0 at slot 10. All outputs return to 0 on the next edge. After release, the startup sequence repeats exactly, including no underrun counted at the first load.

Source files
------------

// File: rtl/mod_i2s_tx.sv
// mod_i2s_tx: mono I2S transmitter. Requests one sample per frame, saturates
// the signed 18.14 sample to 24-bit PCM and shifts it out on both channels.
//
// Sample handshake: o_trigger is a one-cycle request issued once per frame.
// The source answers with a one-cycle i_ready pulse, and i_sample is taken
// only in that cycle. The sample goes into a holding register and is picked
// up at the next frame load. If no sample is waiting at a load, the previous
// frame word is sent again. If a second sample arrives before the load, it
// replaces the first one.
module mod_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_sample,
    input  logic        i_ready,
    output logic        o_trigger,
    output logic        o_bclk,
    output logic        o_lrclk,
    output logic        o_sdata,
    output logic [15:0] o_underrun_cnt,
    output logic        o_overrun
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic signed [41:0] PCM_MAX = 42'sd8388607;
    localparam logic signed [41:0] PCM_MIN = -42'sd8388608;

    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_bclk;
    logic [5:0]         r_slot;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_trigger;
    logic [15:0]        r_underrun_cnt;
    logic               r_overrun;
    logic [31:0]        r_hold;
    logic               r_valid;
    logic [23:0]        r_frame;
    logic               r_first;

    logic               w_div_wrap;
    logic               w_fe;
    logic               w_load;
    logic [5:0]         w_slot_nxt;
    logic               w_lrclk_nxt;
    logic [4:0]         w_bit_idx;
    logic               w_sdata_nxt;
    logic signed [41:0] w_scaled;
    logic [23:0]        w_sat;

    // A falling BCLK edge is the divider wrap while BCLK is high.
    assign w_div_wrap  = (r_div_cnt == DIV_LAST);
    assign w_fe        = w_div_wrap && r_bclk;
    assign w_slot_nxt  = r_slot + 6'd1;
    assign w_load      = w_fe && (w_slot_nxt == 6'd63);

    // Word select covers slots 31..62, one BCLK ahead of the right word.
    assign w_lrclk_nxt = (w_slot_nxt >= 6'd31) && (w_slot_nxt <= 6'd62);

    // Slots 0..23 and 32..55 share the same low five bits, so one index
    // serves both channels. All other slots carry zero.
    assign w_bit_idx   = 5'd23 - w_slot_nxt[4:0];
    assign w_sdata_nxt = (w_slot_nxt[4:0] < 5'd24) ? r_frame[w_bit_idx] : 1'b0;

    // The 18.14 value times 512 puts bit 14 (1.0) at bit 23. The product is
    // computed wide so that it can be clamped without overflow.
    assign w_scaled = $signed({{10{r_hold[31]}}, r_hold}) <<< 9;

    // Clamp the scaled sample to the signed 24-bit PCM range.
    always_comb begin
        w_sat = w_scaled[23:0];
        if (w_scaled > PCM_MAX) begin
            w_sat = 24'h7FFFFF;
        end else if (w_scaled < PCM_MIN) begin
            w_sat = 24'h800000;
        end
    end

    // BCLK divider, slot counter and the I2S output registers. The output
    // registers change only on falling BCLK edges.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_slot    <= 6'd62;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fe) begin
                r_slot  <= w_slot_nxt;
                r_lrclk <= w_lrclk_nxt;
                r_sdata <= w_sdata_nxt;
            end
        end
    end

    // Frame load when entering slot 63. This block also issues the request
    // pulse and keeps the underrun count. The first load after reset is not
    // counted, because no source could have answered yet.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_trigger      <= 1'b0;
            r_frame        <= '0;
            r_underrun_cnt <= '0;
            r_first        <= 1'b1;
        end else begin
            r_trigger <= w_load;
            if (w_load) begin
                r_first <= 1'b0;
                if (r_valid) begin
                    r_frame <= w_sat;
                end else if (!r_first && (r_underrun_cnt != 16'hFFFF)) begin
                    r_underrun_cnt <= r_underrun_cnt + 16'd1;
                end
            end
        end
    end

    // Holding register. A load clears valid first, and a write in the same
    // cycle then sets it again for the next frame. Overrun means a valid
    // sample was overwritten before any load consumed it.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_hold    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_ready) begin
            r_hold  <= i_sample;
            r_valid <= 1'b1;
            if (r_valid && !w_load) begin
                r_overrun <= 1'b1;
            end
        end else if (w_load) begin
            r_valid <= 1'b0;
        end
    end

    assign o_trigger      = r_trigger;
    assign o_bclk         = r_bclk;
    assign o_lrclk        = r_lrclk;
    assign o_sdata        = r_sdata;
    assign o_underrun_cnt = r_underrun_cnt;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_mod_i2s_tx.sv
// tb_mod_i2s_tx: directed bench for mod_i2s_tx with BCLK_DIV = 4. An I2S
// receiver model decodes the serial stream. Each frame's words are compared
// with hand-computed PCM values.
module tb_mod_i2s_tx;
    logic        clk;
    logic        i_nrst;
    logic [31:0] i_sample;
    logic        i_ready;
    logic        o_trigger;
    logic        o_bclk;
    logic        o_lrclk;
    logic        o_sdata;
    logic [15:0] o_underrun_cnt;
    logic        o_overrun;

    int n_vec = 0;
    int n_err = 0;

    mod_i2s_tx #(.BCLK_DIV(4)) dut (
        .i_clk          (clk),
        .i_nrst         (i_nrst),
        .i_sample       (i_sample),
        .i_ready        (i_ready),
        .o_trigger      (o_trigger),
        .o_bclk         (o_bclk),
        .o_lrclk        (o_lrclk),
        .o_sdata        (o_sdata),
        .o_underrun_cnt (o_underrun_cnt),
        .o_overrun      (o_overrun)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2S receiver model: samples data on BCLK rising edges. A change of
    // word select marks the slot before an MSB.
    int          rx_pos  = -2;
    int          pad_err = 0;
    logic        prev_bclk = 1'b0;
    logic        prev_lr   = 1'b0;
    logic [23:0] rx_sh     = '0;
    logic [23:0] rx_l[$];
    logic [23:0] rx_r[$];

    always begin
        @(posedge clk);
        #1;
        if (!i_nrst) begin
            rx_pos    = -2;
            prev_bclk = 1'b0;
            prev_lr   = 1'b0;
            rx_sh     = '0;
        end else begin
            if (o_bclk && !prev_bclk) begin
                if (o_lrclk != prev_lr) rx_pos = 0;
                else rx_pos++;
                prev_lr = o_lrclk;
                if (rx_pos >= 1 && rx_pos <= 24) begin
                    rx_sh = {rx_sh[22:0], o_sdata};
                    if (rx_pos == 24) begin
                        if (o_lrclk) rx_r.push_back(rx_sh);
                        else rx_l.push_back(rx_sh);
                    end
                end else if (o_sdata) begin
                    pad_err++;
                end
            end
            prev_bclk = o_bclk;
        end
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [23:0] exp);
        if (rx_l.size() == 0 || rx_r.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no decoded frame, expected %h", name, exp);
        end else begin
            check({name, "_L"}, {8'h00, rx_l.pop_front()}, {8'h00, exp});
            check({name, "_R"}, {8'h00, rx_r.pop_front()}, {8'h00, exp});
        end
    endtask

    // Driver tasks
    task automatic wait_trigger(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_trigger && n < 600);
        if (!o_trigger) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no o_trigger within 600 cycles", name);
        end
    endtask

    task automatic pulse(input logic [31:0] s);
        i_ready  = 1'b1;
        i_sample = s;
        @(posedge clk);
        #1;
        i_ready  = 1'b0;
        i_sample = $urandom;
    endtask

    // Reset, then check the startup cycle by cycle. A sample is supplied
    // in the first frame, and the task returns just after the second
    // trigger.
    task automatic startup(input string tag, input logic [31:0] s);
        int cyc;
        i_ready = 1'b0;
        i_nrst  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_rst_out"}, {27'd0, o_bclk, o_lrclk, o_sdata, o_trigger, o_overrun}, 32'd0);
        check({tag, "_rst_ur"}, {16'd0, o_underrun_cnt}, 32'd0);
        rx_l.delete();
        rx_r.delete();
        i_nrst = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_bclk_c%0d", tag, c), {31'd0, o_bclk}, {31'd0, (c >= 4 && c < 8)});
            check($sformatf("%s_trig_c%0d", tag, c), {31'd0, o_trigger}, {31'd0, (c == 8)});
            if (c == 8) check({tag, "_lr_first_fe"}, {31'd0, o_lrclk}, 32'd0);
        end
        check({tag, "_ur_first_load"}, {16'd0, o_underrun_cnt}, 32'd0);
        cyc = 9;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            i_ready  = (cyc == 100);
            i_sample = s;
        end while (!o_trigger && cyc < 700);
        i_ready = 1'b0;
        check({tag, "_period"}, 32'(cyc), 32'd520);
        check({tag, "_ur_second_load"}, {16'd0, o_underrun_cnt}, 32'd0);
        check_frame({tag, "_frame0"}, 24'h000000);
    endtask

    typedef struct {
        logic [31:0] sample;
        logic        respond;
        logic [23:0] exp_word;
        logic [15:0] exp_ur;
    } vec_t;

    vec_t        vecs[14];
    logic [23:0] exp_prev;

    initial begin
        vecs[0]  = '{32'h00002000, 1'b1, 24'h400000, 16'd0};
        vecs[1]  = '{32'hFFFFE000, 1'b1, 24'hC00000, 16'd0};
        vecs[2]  = '{32'h00000001, 1'b1, 24'h000200, 16'd0};
        vecs[3]  = '{32'h00004000, 1'b1, 24'h7FFFFF, 16'd0};
        vecs[4]  = '{32'h00050000, 1'b1, 24'h7FFFFF, 16'd0};
        vecs[5]  = '{32'hFFFFC000, 1'b1, 24'h800000, 16'd0};
        vecs[6]  = '{32'hFFFB0000, 1'b1, 24'h800000, 16'd0};
        vecs[7]  = '{32'h00001000, 1'b1, 24'h200000, 16'd0};
        vecs[8]  = '{32'h00000000, 1'b0, 24'h200000, 16'd1};
        vecs[9]  = '{32'h00000000, 1'b0, 24'h200000, 16'd2};
        vecs[10] = '{32'h00003FFF, 1'b1, 24'h7FFE00, 16'd2};
        vecs[11] = '{32'hFFFFC001, 1'b1, 24'h800200, 16'd2};
        vecs[12] = '{32'hFFFFFFFF, 1'b1, 24'hFFFE00, 16'd2};
        vecs[13] = '{32'h00000FFF, 1'b1, 24'h1FFE00, 16'd2};

        i_nrst   = 1'b0;
        i_ready  = 1'b0;
        i_sample = '0;

        // Startup sequence, first frame answered with 0x1800
        startup("start", 32'h00001800);
        exp_prev = 24'h300000;

        // Table-driven frames: a word shows up one frame after its answer
        for (int k = 0; k < 14; k++) begin
            repeat (20 + 31 * k) @(posedge clk);
            #1;
            if (vecs[k].respond) pulse(vecs[k].sample);
            wait_trigger($sformatf("vec%0d_trig", k));
            check($sformatf("vec%0d_ur", k), {16'd0, o_underrun_cnt}, {16'd0, vecs[k].exp_ur});
            check_frame($sformatf("vec%0d_frame", k), exp_prev);
            exp_prev = vecs[k].exp_word;
        end
        check("no_overrun_yet", {31'd0, o_overrun}, 32'd0);

        // Overrun: two samples in one frame, the last one wins
        repeat (10) @(posedge clk);
        #1;
        pulse(32'h00001000);
        check("ovr_single", {31'd0, o_overrun}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        pulse(32'h00002000);
        check("ovr_double", {31'd0, o_overrun}, 32'd1);
        wait_trigger("ovr_trig");
        check_frame("vec13_last", exp_prev);

        // Collision: a sample arrives in the load cycle itself
        repeat (511) @(posedge clk);
        #1;
        i_ready  = 1'b1;
        i_sample = 32'h00000800;
        @(posedge clk);
        #1;
        i_ready  = 1'b0;
        check("coll_align", {31'd0, o_trigger}, 32'd1);
        check_frame("ovr_frame", 24'h400000);
        wait_trigger("coll_trig");
        check_frame("coll_old", 24'h400000);
        check("ovr_sticky", {31'd0, o_overrun}, 32'd1);

        // Underrun counter saturation
        force dut.r_underrun_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_underrun_cnt;
        wait_trigger("sat_trig");
        check("ur_saturate", {16'd0, o_underrun_cnt}, 32'h0000FFFF);
        check_frame("coll_new", 24'h100000);

        // Mid-frame reset at slot 10, then the full startup again
        repeat (89) @(posedge clk);
        #1;
        i_nrst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out", {27'd0, o_bclk, o_lrclk, o_sdata, o_trigger, o_overrun}, 32'd0);
        check("midrst_ur", {16'd0, o_underrun_cnt}, 32'd0);
        startup("restart", 32'hFFFFF000);
        wait_trigger("restart_trig2");
        check("restart_ur", {16'd0, o_underrun_cnt}, 32'd1);
        check_frame("restart_frame1", 24'hE00000);

        check("pad_bits_zero", 32'(pad_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
